fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the address of the first instruction fetched after reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  SHALL be synchronous and active-high.
REQ-004 Port imem_req_valid  output  1  SHALL indicate an instruction-memory read request.
REQ-005 Port imem_req_ready  input  1  SHALL indicate that memory accepts the request this cycle.
REQ-006 Port imem_addr  output  32  SHALL carry the request word address.
REQ-007 Port imem_resp_valid  input  1  SHALL indicate that imem_resp_data holds the requested word.
REQ-008 Port imem_resp_data  input  32  SHALL carry the returned instruction word.
REQ-009 Port i_fetch  output  32  SHALL carry the instruction presented to decode.
REQ-010 Port pc  output  32  SHALL carry the address of i_fetch.
REQ-011 Port fetch_valid  output  1  SHALL indicate that i_fetch/pc are valid for decode.
REQ-012 Port decode_ready  input  1  SHALL indicate that decode consumes the instruction this cycle.
REQ-013 Port next_pc  input  32  SHALL carry decode's computed successor address, sampled on accept.
REQ-014 Port fault  output  1  SHALL be a sticky misaligned-fetch indicator.
REQ-015 Port fetch_count  output  32  SHALL count instructions accepted by decode.

Function
REQ-016 The FSM SHALL have four states: S_REQ, S_WAIT, S_HOLD and S_FAULT.
REQ-017 In S_REQ: imem_req_valid=1 and imem_addr=pc_reg; on imem_req_ready=1 the FSM SHALL go to S_WAIT, else remain in S_REQ with address held stable.
REQ-018 In S_WAIT: imem_req_valid=0; on imem_resp_valid=1 the unit SHALL latch imem_resp_data into the instruction register and go to S_HOLD.
REQ-019 In S_HOLD: fetch_valid=1, i_fetch=instruction register, pc=pc_reg; both SHALL stay stable until accept.
REQ-020 Accept is defined as fetch_valid && decode_ready. On accept: pc_reg<=next_pc, fetch_count increments, and the FSM goes to S_REQ.
REQ-021 If next_pc[1:0]!=2'b00 at accept, the unit SHALL instead go to S_FAULT, set fault=1, leave pc_reg unchanged and still increment fetch_count.
REQ-022 S_FAULT SHALL be terminal until reset: imem_req_valid=0, fetch_valid=0, fault=1.
REQ-023 imem_resp_valid in any state other than S_WAIT SHALL be ignored, with no state or data change.
REQ-024 Only one request SHALL be outstanding at a time.
REQ-025 Minimum latency SHALL be 3 cycles from entering S_REQ to the next S_REQ, with zero-wait memory and decode_ready=1.
REQ-026 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-027 fetch_valid SHALL be 0 in every state except S_HOLD; i_fetch SHALL hold its last latched value outside S_HOLD.

Reset
REQ-028 Reset SHALL override all other inputs in any state, including mid-S_WAIT and S_FAULT.
REQ-029 Reset values: state=S_REQ, pc_reg=RESET_PC, instruction register=0, fetch_count=0, fault=0.
REQ-030 Output reset values: imem_req_valid=1, imem_addr=RESET_PC, fetch_valid=0.
REQ-031 A response arriving in the cycle after reset SHALL be ignored, because the FSM is in S_REQ.

Verification
REQ-032 Reset then imem_req_ready=1, response 32'h2408_0005 one cycle later, decode_ready=1, next_pc=32'h4 -> the fetch of address 0 is presented with pc=0, the next request uses imem_addr=32'h4, and fetch_count=1.
REQ-033 Hold imem_req_ready=0 for 5 cycles -> imem_req_valid=1 and imem_addr constant throughout; no fetch_valid.
REQ-034 In S_HOLD, hold decode_ready=0 for 4 cycles while toggling imem_resp_valid -> i_fetch/pc stable, no new request issued.
REQ-035 Accept with next_pc=32'h0000_0102 -> fault=1, pc stays at the old value, no further requests; a following reset clears fault and restarts at RESET_PC.
REQ-036 Assert reset during S_WAIT, then deliver the stale response -> response ignored, fresh request to RESET_PC issued.
REQ-037 Force fetch_count=32'hFFFF_FFFF, then perform one accept -> fetch_count=0.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Single-outstanding instruction fetch FSM with decode handshake
//               and a sticky misaligned-target fault.
// Revision    : 1.0
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] i_fetch,
    output logic [31:0] pc,
    output logic        fetch_valid,
    input  logic        decode_ready,
    input  logic [31:0] next_pc,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] count_q;
    logic        fault_q;

    logic        accept;
    logic        misaligned;

    assign accept     = (state_q == S_HOLD) && decode_ready;
    assign misaligned = (next_pc[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:   if (imem_req_ready)  state_d = S_WAIT;
            S_WAIT:  if (imem_resp_valid) state_d = S_HOLD;
            S_HOLD:  if (decode_ready)    state_d = misaligned ? S_FAULT : S_REQ;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_REQ;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req_valid = 1'b0;
        fetch_valid    = 1'b0;
        case (state_q)
            S_REQ:   imem_req_valid = 1'b1;
            S_HOLD:  fetch_valid    = 1'b1;
            default: begin
                imem_req_valid = 1'b0;
                fetch_valid    = 1'b0;
            end
        endcase
    end

    // Datapath: responses outside S_WAIT never touch the instruction register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
            count_q <= 32'h0000_0000;
            fault_q <= 1'b0;
        end else begin
            if ((state_q == S_WAIT) && imem_resp_valid) begin
                instr_q <= imem_resp_data;
            end
            if (accept) begin
                count_q <= count_q + 32'd1;
                if (misaligned) begin
                    fault_q <= 1'b1;
                end else begin
                    pc_q <= next_pc;
                end
            end
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign i_fetch     = instr_q;
    assign fault       = fault_q;
    assign fetch_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] i_fetch;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        decode_ready;
    logic [31:0] next_pc;
    logic        fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .i_fetch         (i_fetch),
        .pc              (pc),
        .fetch_valid     (fetch_valid),
        .decode_ready    (decode_ready),
        .next_pc         (next_pc),
        .fault           (fault),
        .fetch_count     (fetch_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0; decode_ready = 1'b0; next_pc = 32'h0;
        step(); step();

        // Reset values
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_ifetch", i_fetch, 32'h0);

        // Response right after reset is ignored
        reset = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
        step();
        imem_resp_valid = 1'b0;
        check("post_rst_resp_ifetch", i_fetch, 32'h0);
        check("post_rst_resp_req", {31'b0, imem_req_valid}, 32'd1);

        // Memory not ready for 5 cycles: request held
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
            check("stall_addr", imem_addr, 32'h0);
            check("stall_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        end

        // First fetch
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("wait_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        imem_resp_valid = 1'b1; imem_resp_data = 32'h2408_0005;
        step();
        imem_resp_valid = 1'b0;
        check("hold_fetch_valid", {31'b0, fetch_valid}, 32'd1);
        check("hold_ifetch", i_fetch, 32'h2408_0005);
        check("hold_pc", pc, 32'h0);

        // Decode stalls while stray responses toggle
        for (int i = 0; i < 4; i++) begin
            imem_resp_valid = (i % 2 == 0); imem_resp_data = 32'h1111_0000 + i;
            step();
            check("stall_ifetch", i_fetch, 32'h2408_0005);
            check("stall_pc", pc, 32'h0);
            check("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
            check("stall_valid", {31'b0, fetch_valid}, 32'd1);
        end
        imem_resp_valid = 1'b0;

        // Accept with aligned successor
        decode_ready = 1'b1; next_pc = 32'h4;
        step();
        decode_ready = 1'b0;
        check("acc_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("acc_addr", imem_addr, 32'h4);
        check("acc_count", fetch_count, 32'd1);
        check("acc_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        check("acc_ifetch_held", i_fetch, 32'h2408_0005);

        // Second fetch, then misaligned accept
        imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'hAAAA_5555; step();
        imem_resp_valid = 1'b0;
        check("f2_pc", pc, 32'h4);
        check("f2_ifetch", i_fetch, 32'hAAAA_5555);
        decode_ready = 1'b1; next_pc = 32'h0000_0102;
        step();
        decode_ready = 1'b0;
        check("flt_fault", {31'b0, fault}, 32'd1);
        check("flt_pc", pc, 32'h4);
        check("flt_count", fetch_count, 32'd2);
        check("flt_req_valid", {31'b0, imem_req_valid}, 32'd0);

        // Fault is terminal
        imem_req_ready = 1'b1; imem_resp_valid = 1'b1; decode_ready = 1'b1; next_pc = 32'h8;
        for (int i = 0; i < 3; i++) begin
            step();
            check("flt_sticky", {31'b0, fault}, 32'd1);
            check("flt_no_req", {31'b0, imem_req_valid}, 32'd0);
            check("flt_no_valid", {31'b0, fetch_valid}, 32'd0);
            check("flt_count_held", fetch_count, 32'd2);
        end
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; decode_ready = 1'b0;

        // Reset clears the fault
        reset = 1'b1; step(); reset = 1'b0;
        check("clr_fault", {31'b0, fault}, 32'd0);
        check("clr_addr", imem_addr, 32'h0);
        check("clr_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("clr_count", fetch_count, 32'd0);

        // Reset mid-S_WAIT, stale response ignored
        imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
        check("w2_req_valid", {31'b0, imem_req_valid}, 32'd0);
        reset = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'hCAFE_F00D;
        step();
        reset = 1'b0;
        step();
        imem_resp_valid = 1'b0;
        check("stale_ifetch", i_fetch, 32'h0);
        check("stale_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        check("stale_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("stale_addr", imem_addr, 32'h0);

        // Counter wrap
        dut.count_q = 32'hFFFF_FFFF;
        imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013; step();
        imem_resp_valid = 1'b0;
        check("wrap_pre", fetch_count, 32'hFFFF_FFFF);
        decode_ready = 1'b1; next_pc = 32'h8;
        step();
        decode_ready = 1'b0;
        check("wrap_count", fetch_count, 32'h0);
        check("wrap_addr", imem_addr, 32'h8);
        check("wrap_fault", {31'b0, fault}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
